// File: rtl/contador_regressivo_p.sv
// Loadable down-counter used as the elevator controller's door/travel timer.
// Emits a one-cycle fim pulse on expiry, a halfway flag (meio) and a busy flag (ocupado).
module contador_regressivo_p #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         conta,
    input  logic         pausa,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         ocupado
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] UM   = {{(N-1){1'b0}}, 1'b1};

    estado_t      estado_reg, estado_next;
    logic [N-1:0] q_reg, q_next;
    logic [N-1:0] carga_reg, carga_next;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            estado_reg <= PARADO;
            q_reg      <= ZERO;
            carga_reg  <= ZERO;
        end else begin
            estado_reg <= estado_next;
            q_reg      <= q_next;
            carga_reg  <= carga_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        q_next      = q_reg;
        carga_next  = carga_reg;
        if (carrega) begin
            // A load overrides pausa/conta and restarts from the new value.
            q_next      = valor;
            carga_next  = valor;
            estado_next = (valor == ZERO) ? FIM : CONTANDO;
        end else begin
            case (estado_reg)
                PARADO: begin
                end
                CONTANDO: begin
                    if (pausa) begin
                        estado_next = PAUSADO;
                    end else if (conta) begin
                        // <= 1 also guards against ever wrapping below zero.
                        if (q_reg <= UM) begin
                            q_next      = ZERO;
                            estado_next = FIM;
                        end else begin
                            q_next = q_reg - UM;
                        end
                    end
                end
                PAUSADO: begin
                    if (!pausa) begin
                        estado_next = CONTANDO;
                    end
                end
                FIM: begin
                    estado_next = PARADO;
                end
                default: begin
                    estado_next = PARADO;
                end
            endcase
        end
    end

    assign Q       = q_reg;
    assign fim     = (estado_reg == FIM);
    assign ocupado = (estado_reg == CONTANDO) || (estado_reg == PAUSADO);
    assign meio    = ocupado && (q_reg == (carga_reg >> 1));

endmodule

// File: tb/tb_contador_regressivo_p.sv
// Scoreboard bench for contador_regressivo_p: stimulus queues the expected outputs
// for each edge, and a negedge monitor pops and compares them.
module tb_contador_regressivo_p;

    logic       clock;
    logic       zera_s;
    logic       carrega;
    logic [7:0] valor;
    logic       conta;
    logic       pausa;
    logic [7:0] Q;
    logic       fim;
    logic       meio;
    logic       ocupado;

    typedef struct {
        logic [7:0] q;
        logic       fim;
        logic       meio;
        logic       ocupado;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tx     = 0;

    contador_regressivo_p #(.N(8)) dut (
        .clock   (clock),
        .zera_s  (zera_s),
        .carrega (carrega),
        .valor   (valor),
        .conta   (conta),
        .pausa   (pausa),
        .Q       (Q),
        .fim     (fim),
        .meio    (meio),
        .ocupado (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every edge produces one output transaction, checked at the following negedge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            tx++;
            if (Q !== e.q || fim !== e.fim || meio !== e.meio || ocupado !== e.ocupado) begin
                errors++;
                $display("FAIL %s: got Q=%0d fim=%b meio=%b ocupado=%b, expected Q=%0d fim=%b meio=%b ocupado=%b",
                         e.name, Q, fim, meio, ocupado, e.q, e.fim, e.meio, e.ocupado);
            end else begin
                $display("tx %0d %s: Q=%0d fim=%b meio=%b ocupado=%b ok",
                         tx, e.name, Q, fim, meio, ocupado);
            end
        end
    end

    // Drive one edge worth of inputs and queue the outputs expected after that edge.
    task automatic step(input logic z, input logic c, input logic [7:0] v,
                        input logic ct, input logic p,
                        input logic [7:0] eq, input logic ef, input logic em,
                        input logic eo, input string nm);
        exp_t e;
        @(negedge clock);
        #1;
        zera_s  = z;
        carrega = c;
        valor   = v;
        conta   = ct;
        pausa   = p;
        e.q = eq; e.fim = ef; e.meio = em; e.ocupado = eo; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        zera_s = 1'b1; carrega = 1'b0; valor = 8'd0; conta = 1'b0; pausa = 1'b0;

        // Reset, then idle with conta/pausa toggling
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, "reset1");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "idle_conta");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_pausa");
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, "idle_both");

        // Load 5, conta held high
        step(0, 1, 5, 1, 0, 5, 0, 0, 1, "l5_load");
        step(0, 0, 0, 1, 0, 4, 0, 0, 1, "l5_q4");
        step(0, 0, 0, 1, 0, 3, 0, 0, 1, "l5_q3");
        step(0, 0, 0, 1, 0, 2, 0, 1, 1, "l5_q2_meio");
        step(0, 0, 0, 1, 0, 1, 0, 0, 1, "l5_q1");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "l5_fim");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l5_after");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l5_hold");

        // Load 6, pause for 3 cycles at Q=4 (pausa beats conta)
        step(0, 1, 6, 1, 0, 6, 0, 0, 1, "l6_load");
        step(0, 0, 0, 1, 0, 5, 0, 0, 1, "l6_q5");
        step(0, 0, 0, 1, 0, 4, 0, 0, 1, "l6_q4");
        step(0, 0, 0, 1, 1, 4, 0, 0, 1, "l6_pause1");
        step(0, 0, 0, 1, 1, 4, 0, 0, 1, "l6_pause2");
        step(0, 0, 0, 1, 1, 4, 0, 0, 1, "l6_pause3");
        step(0, 0, 0, 1, 0, 4, 0, 0, 1, "l6_resume");
        step(0, 0, 0, 1, 0, 3, 0, 1, 1, "l6_q3_meio");
        step(0, 0, 0, 1, 0, 2, 0, 0, 1, "l6_q2");
        step(0, 0, 0, 0, 0, 2, 0, 0, 1, "l6_noconta");
        step(0, 0, 0, 1, 0, 1, 0, 0, 1, "l6_q1");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "l6_fim");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l6_after");

        // Load 0: immediate expiry
        step(0, 1, 0, 1, 0, 0, 1, 0, 0, "l0_fim");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l0_after");

        // Load 8, reload 2 at Q=3
        step(0, 1, 8, 1, 0, 8, 0, 0, 1, "l8_load");
        step(0, 0, 0, 1, 0, 7, 0, 0, 1, "l8_q7");
        step(0, 0, 0, 1, 0, 6, 0, 0, 1, "l8_q6");
        step(0, 0, 0, 1, 0, 5, 0, 0, 1, "l8_q5");
        step(0, 0, 0, 1, 0, 4, 0, 1, 1, "l8_q4_meio");
        step(0, 0, 0, 1, 0, 3, 0, 0, 1, "l8_q3");
        step(0, 1, 2, 1, 0, 2, 0, 0, 1, "rl2_load");
        step(0, 0, 0, 1, 0, 1, 0, 1, 1, "rl2_q1_meio");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "rl2_fim");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "rl2_after");

        // Load 1 (meio never), then reload 3 during FIM
        step(0, 1, 1, 0, 0, 1, 0, 0, 1, "l1_load");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "l1_fim");
        step(0, 1, 3, 1, 0, 3, 0, 0, 1, "fim_reload3");
        step(0, 0, 0, 1, 0, 2, 0, 0, 1, "l3_q2");
        step(0, 0, 0, 1, 0, 1, 0, 1, 1, "l3_q1_meio");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "l3_fim");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "l3_after");

        // Reset and load together: reset wins
        step(1, 1, 9, 1, 0, 0, 0, 0, 0, "reset_vs_load");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_vs_load_idle");

        // Load 255, reset mid-count at Q=100
        step(0, 1, 255, 1, 0, 255, 0, 0, 1, "l255_load");
        for (int i = 1; i <= 155; i++) begin
            logic [7:0] eq;
            eq = 8'(255 - i);
            step(0, 0, 0, 1, 0, eq, 0, (eq == 8'd127), 1, "l255_count");
        end
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, "l255_reset_at_100");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l255_after_reset1");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "l255_after_reset2");

        // Full run of 255: exactly 255 conta ticks to expiry
        step(0, 1, 255, 0, 0, 255, 0, 0, 1, "full_load");
        for (int i = 1; i <= 254; i++) begin
            logic [7:0] eq;
            eq = 8'(255 - i);
            step(0, 0, 0, 1, 0, eq, 0, (eq == 8'd127), 1, "full_count");
        end
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, "full_fim_tick255");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "full_after");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "full_hold");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending transactions, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_regressivo_p.md
Name: contador_regressivo_p

Overview:
- Loadable down-counter (countdown timer) for the elevator controller.
- Used for door-open and travel timeouts.
- Counts down from a runtime-loaded value, not up from 0.
- Outputs: a one-cycle fim pulse on expiry, a meio flag at the halfway point, and a busy flag.
- Sits between the control FSM (load/pause commands) and a tick source driving conta.

Parameters:
N, 8, width of counter value and load value (max count 2^N-1)

Ports:
clock  input  1  system clock, all state updates on rising edge
zera_s  input  1  synchronous active-high reset; clears all state
carrega  input  1  load request: Q <= valor, start countdown
valor  input  N  countdown start value, sampled when carrega=1
conta  input  1  decrement enable (tick); ignored unless counting
pausa  input  1  freeze countdown while high
Q  output  N  current count value
fim  output  1  one-cycle pulse: countdown reached 0
meio  output  1  high while counting/paused and Q == carga/2 (floor)
ocupado  output  1  high while countdown active (CONTANDO or PAUSADO)

Behaviour:
- Single clock domain.
- zera_s is synchronous and active-high, and has highest priority.
- Input priority each edge: zera_s > carrega > pausa > conta.
- Internal registers: Q[N-1:0], carga[N-1:0] (latched load value), estado (2 bits).
- Reset values: Q=0, carga=0, estado=PARADO, fim=0, meio=0, ocupado=0.

States:
- PARADO: idle. Q holds. conta and pausa ignored.
- CONTANDO: on conta=1 and pausa=0:
  - If Q==1: Q<=0, go to FIM.
  - Otherwise: Q<=Q-1.
  - If pausa=1: go to PAUSADO, no decrement that cycle (pausa wins over a simultaneous conta).
- PAUSADO: Q holds. pausa=0 returns to CONTANDO. The first decrement can occur on the edge after return.
- FIM: held for exactly one cycle, then go to PARADO. Q stays 0.

Load (carrega=1) in any state:
- Q<=valor, carga<=valor.
- valor!=0: go to CONTANDO.
- valor==0: go to FIM (immediate expiry pulse).
- conta/pausa on the same edge are ignored.
- Reload mid-count restarts from the new value. No fim is produced for the aborted count.

Outputs:
- fim = (estado==FIM). It is registered via state, so never combinational from inputs.
- Latency: conta sampled with Q==1 at edge k gives Q=0 and fim=1 during the cycle after edge k, and fim=0 after edge k+1.
- meio = ocupado && (Q == carga>>1). Combinational from registers only.
  - For carga=1, meio never asserts (Q=0 is never reached while ocupado).
- ocupado = (estado==CONTANDO || estado==PAUSADO).

Boundary conditions:
- Maximum load 2^N-1 counts down correctly with no wrap.
- The counter never decrements below 0 and never wraps.
- conta held high continuously decrements once per clock.
- zera_s mid-count: next cycle Q=0, PARADO, no fim pulse.
- zera_s and carrega together: reset wins.
- carrega during FIM: the new load takes effect, and fim is not extended beyond its single cycle.

Test Plan:
- Reset then idle: assert zera_s 2 cycles, toggle conta/pausa -> Q=0, fim=0, meio=0, ocupado=0 throughout.
- Load valor=5, conta held high -> ocupado=1; Q sequence 5,4,3,2,1,0; meio=1 only while Q=2; fim=1 for exactly one cycle coincident with Q=0; then ocupado=0, Q holds 0.
- Load valor=6, conta high, pausa high for 3 cycles after Q=4 -> Q holds 4 for the pause duration; on release, continues 3,2,1,0 with a single fim pulse; meio=1 while Q=3 both before and after the pause as applicable.
- Load valor=0 -> next cycle fim=1, ocupado=0, Q=0; the cycle after, fim=0.
- Load valor=8, count to Q=3, reload valor=2 -> Q=2 next cycle, carga=2, meio=1 at Q=1; one fim pulse total; no pulse for the aborted count.
- N=8, load valor=255, conta high; assert zera_s at Q=100 -> Q=0, PARADO, fim never pulses; a separate run to completion takes 255 conta cycles with a single fim.
